fft_bfly_seq: RTL and testbench

- Sequencer for an in-place radix-2 DIT 256-point FFT.
- Each cycle it issues one butterfly's two data-RAM read addresses together with the matching twiddle ROM address.
- It delays those addresses to produce write-back addresses and a write enable aligned with the butterfly datapath output.
- It sits upstream of the twiddle ROM and butterfly datapath, between the frame buffer (bit-reversed input) and the MVDR covariance stage.

---
 rtl/fft_pkg.sv | 23 ++
 rtl/fft_addr_dly.sv | 42 ++++
 rtl/fft_bfly_seq.sv | 119 +++++++++++
 tb/tb_fft_bfly_seq.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared constants for the 256-point radix-2 FFT: sizes, latencies and address widths.
package fft_pkg;

    localparam int unsigned N        = 256;
    localparam int unsigned LOG2N    = 8;
    localparam int unsigned PIPE_LAT = 4;

    localparam int unsigned STG_W  = $clog2(LOG2N);
    localparam int unsigned ADDR_W = LOG2N;
    localparam int unsigned TW_W   = LOG2N - 1;
    localparam int unsigned J_W    = LOG2N - 1;

    // Write-back delay: one cycle of RAM/ROM read plus the butterfly pipeline.
    localparam int unsigned WB_DLY = 1 + PIPE_LAT;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_DRAIN,
        ST_DONE
    } seq_state_e;

endpackage

// File: rtl/fft_addr_dly.sv
// Fixed-depth shift register carrying {valid, addr_a, addr_b} from issue to write-back.
module fft_addr_dly #(
    parameter int unsigned DEPTH = 5,
    parameter int unsigned AW    = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          vld_i,
    input  logic [AW-1:0] a_i,
    input  logic [AW-1:0] b_i,
    output logic          vld_o,
    output logic [AW-1:0] a_o,
    output logic [AW-1:0] b_o
);

    logic [DEPTH-1:0] vld_q;
    logic [AW-1:0]    a_q [DEPTH];
    logic [AW-1:0]    b_q [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                a_q[i] <= '0;
                b_q[i] <= '0;
            end
        end else begin
            vld_q  <= {vld_q[DEPTH-2:0], vld_i};
            a_q[0] <= a_i;
            b_q[0] <= b_i;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                a_q[i] <= a_q[i-1];
                b_q[i] <= b_q[i-1];
            end
        end
    end

    assign vld_o = vld_q[DEPTH-1];
    assign a_o   = a_q[DEPTH-1];
    assign b_o   = b_q[DEPTH-1];

endmodule

// File: rtl/fft_bfly_seq.sv
// In-place radix-2 DIT butterfly sequencer: read/twiddle addresses per cycle, delayed write-back.
module fft_bfly_seq
    import fft_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [STG_W-1:0]  stage,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr_a,
    output logic [ADDR_W-1:0] rd_addr_b,
    output logic [TW_W-1:0]   tw_addr,
    output logic              bfly_in_valid,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr_a,
    output logic [ADDR_W-1:0] wr_addr_b
);

    localparam int unsigned DCNT_W = $clog2(WB_DLY + 1);

    seq_state_e        state_q, state_d;
    logic [STG_W-1:0]  stage_q, stage_d;
    logic [J_W-1:0]    j_q, j_d;
    logic [DCNT_W-1:0] dcnt_q, dcnt_d;
    logic              bvld_q;

    logic [ADDR_W-1:0] j_ext, half, mask, a_calc;
    logic [TW_W-1:0]   tw_calc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            stage_q <= '0;
            j_q     <= '0;
            dcnt_q  <= '0;
            bvld_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            stage_q <= stage_d;
            j_q     <= j_d;
            dcnt_q  <= dcnt_d;
            bvld_q  <= rd_en;
        end
    end

    always_comb begin
        state_d = state_q;
        stage_d = stage_q;
        j_d     = j_q;
        dcnt_d  = dcnt_q;
        unique case (state_q)
            ST_IDLE: begin
                stage_d = '0;
                j_d     = '0;
                dcnt_d  = '0;
                if (start) state_d = ST_ISSUE;
            end
            ST_ISSUE: begin
                j_d    = j_q + 1'b1;
                dcnt_d = '0;
                if (j_q == J_W'(N/2 - 1)) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                // Leave DRAIN only once the stage's final write strobe is on the bus.
                dcnt_d = dcnt_q + 1'b1;
                if (dcnt_q == DCNT_W'(WB_DLY - 1)) begin
                    dcnt_d = '0;
                    j_d    = '0;
                    if (stage_q == STG_W'(LOG2N - 1)) begin
                        state_d = ST_DONE;
                    end else begin
                        stage_d = stage_q + 1'b1;
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_DONE: begin
                stage_d = '0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // a = grp*2*half + pos, built from shifts and masks of j.
    always_comb begin
        j_ext   = {1'b0, j_q};
        half    = ADDR_W'(1) << stage_q;
        mask    = half - 1'b1;
        a_calc  = ((j_ext >> stage_q) << ({1'b0, stage_q} + 1'b1)) | (j_ext & mask);
        tw_calc = (j_q & mask[TW_W-1:0]) << (STG_W'(LOG2N - 1) - stage_q);
    end

    assign rd_en         = (state_q == ST_ISSUE);
    assign busy          = (state_q == ST_ISSUE) || (state_q == ST_DRAIN);
    assign done          = (state_q == ST_DONE);
    assign stage         = stage_q;
    assign rd_addr_a     = rd_en ? a_calc : '0;
    assign rd_addr_b     = rd_en ? (a_calc | half) : '0;
    assign tw_addr       = rd_en ? tw_calc : '0;
    assign bfly_in_valid = bvld_q;

    fft_addr_dly #(
        .DEPTH (WB_DLY),
        .AW    (ADDR_W)
    ) u_wb_dly (
        .clk   (clk),
        .rst_n (rst_n),
        .vld_i (rd_en),
        .a_i   (rd_addr_a),
        .b_i   (rd_addr_b),
        .vld_o (wr_en),
        .a_o   (wr_addr_a),
        .b_o   (wr_addr_b)
    );

endmodule

// File: tb/tb_fft_bfly_seq.sv
// Directed/randomized bench for fft_bfly_seq against a cycle-indexed schedule model.
module tb_fft_bfly_seq;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       busy, done, rd_en, bfly_in_valid, wr_en;
    logic [2:0] stage;
    logic [7:0] rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b;
    logic [6:0] tw_addr;

    int checks = 0;
    int errors = 0;

    fft_bfly_seq dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .busy          (busy),
        .done          (done),
        .stage         (stage),
        .rd_en         (rd_en),
        .rd_addr_a     (rd_addr_a),
        .rd_addr_b     (rd_addr_b),
        .tw_addr       (tw_addr),
        .bfly_in_valid (bfly_in_valid),
        .wr_en         (wr_en),
        .wr_addr_a     (wr_addr_a),
        .wr_addr_b     (wr_addr_b)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int cyc, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    // Schedule model: stage s occupies 133 cycles starting at 1+133*s (128 issues + 5 drain).
    function automatic bit issue_at(input int c, output int s, output int j);
        int k;
        s = 0;
        j = 0;
        if (c < 1 || c > 1064) return 1'b0;
        s = (c - 1) / 133;
        k = (c - 1) % 133;
        if (k >= 128) return 1'b0;
        j = k;
        return 1'b1;
    endfunction

    function automatic void golden(input int s, input int j, output int a, output int b, output int tw);
        int half, pos, grp;
        half = 1 << s;
        pos  = j % half;
        grp  = j / half;
        a    = grp * 2 * half + pos;
        b    = a + half;
        tw   = pos * (1 << (7 - s));
    endfunction

    task automatic check_cycle(input int c);
        int  s, j, a, b, tw, ws, wj, wa, wb, wtw, bs, bj;
        bit  iss, wis, bis;
        iss = issue_at(c, s, j);
        wis = issue_at(c - 5, ws, wj);
        bis = issue_at(c - 1, bs, bj);
        chk("rd_en", c, 64'(rd_en), 64'(iss));
        if (iss) begin
            golden(s, j, a, b, tw);
            chk("rd_addr", c, {40'd0, rd_addr_a, rd_addr_b, 1'b0, tw_addr}, {40'd0, a[7:0], b[7:0], 1'b0, tw[6:0]});
        end
        chk("wr_en", c, 64'(wr_en), 64'(wis));
        if (wis) begin
            golden(ws, wj, wa, wb, wtw);
            chk("wr_addr", c, {48'd0, wr_addr_a, wr_addr_b}, {48'd0, wa[7:0], wb[7:0]});
        end
        chk("ctl", c, {61'd0, busy, done, bfly_in_valid},
            {61'd0, (c >= 1 && c <= 1064), (c == 1065), bis});
        if (c >= 1 && c <= 1064)
            chk("stage", c, 64'(stage), 64'((c - 1) / 133));
    endtask

    task automatic check_all_zero(input string tag, input int c);
        chk(tag, c, {23'd0, busy, done, stage, rd_en, rd_addr_a, rd_addr_b, tw_addr,
                     bfly_in_valid, wr_en, wr_addr_a, wr_addr_b}, 64'd0);
    endtask

    // Runs a start-triggered sequence, checking every cycle up to 'last' or aborting at 'rst_at'.
    task automatic run(input int last, input int rst_at);
        int extra;
        extra = $urandom_range(1063, 2);
        for (int c = 0; c <= last; c++) begin
            check_cycle(c);
            if (c == rst_at) begin
                start = 1'b0;
                return;
            end
            start = (c == 0 || c == 500 || c == 1065 || c == extra);
            tick();
        end
        start = 1'b0;
    endtask

    initial begin
        int gap;
        rst_n = 1'b0;
        start = 1'b0;
        #2;
        repeat (3) tick();
        check_all_zero("reset_hold", 0);
        rst_n = 1'b1;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (i % 10 == 0) check_all_zero("idle_no_start", i);
        end

        gap = $urandom_range(9, 1);
        repeat (gap) tick();
        run(1080, -1);

        gap = $urandom_range(9, 1);
        repeat (gap) tick();
        run(1080, 300);
        rst_n = 1'b0;
        #1;
        check_all_zero("reset_mid_run", 300);
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            check_all_zero("after_abort", i);
        end

        run(1080, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
